// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared pointer-width helper, read-mode constants and error-flag type for sync_fifo_flags.
package sync_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    typedef struct packed {
        logic wr_err;
        logic rd_err;
    } fifo_err_t;

    // Pointer carries one extra MSB that toggles on each wrap.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_stage.sv
// sync_fifo_fwft_stage: first-word-fall-through output register with valid bit and prefetch from memory.
module sync_fifo_fwft_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pop_i,
    input  logic                  mem_empty_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  load_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Refill whenever the head slot is free or being vacated this cycle.
    always_comb begin
        load_o  = !mem_empty_i && (!valid_q || pop_i);
        valid_d = load_o || (valid_q && !pop_i);
        data_d  = load_o ? mem_data_i : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with fill count, almost flags, error flags and optional FWFT read.
// Define SYNC_FIFO_ERR_STICKY_EN for sticky wr_err/rd_err cleared by err_clr.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 16,
    parameter int AF_LEVEL   = DATA_DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = FIFO_STD
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        rd_en,
`ifdef SYNC_FIFO_ERR_STICKY_EN
    input  logic                        err_clr,
`endif
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [$clog2(DATA_DEPTH):0] count,
    output logic                        wr_err,
    output logic                        rd_err
);

    localparam int            PW      = ptr_w(DATA_DEPTH);
    localparam int            AW      = PW - 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DATA_DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d, mem_cnt;
    fifo_err_t             err_q, err_d, new_err;
    logic                  rd_acc, wr_acc, rd_adv, fifo_empty, out_valid;
    logic [DATA_WIDTH-1:0] rd_data;

    assign full         = count_q == DEPTH_C;
    assign empty        = fifo_empty;
    assign almost_full  = count_q >= AF_C;
    assign almost_empty = count_q <= AE_C;
    assign count        = count_q;
    assign data_out     = rd_data;
    assign wr_err       = err_q.wr_err;
    assign rd_err       = err_q.rd_err;
    assign mem_cnt      = wr_ptr_q - rd_ptr_q;
    assign rd_acc       = rd_en && !fifo_empty;
    assign wr_acc       = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d       = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d       = rd_ptr_q + PW'(rd_adv);
        count_d        = count_q + PW'(wr_acc && !rd_acc) - PW'(rd_acc && !wr_acc);
        new_err.wr_err = wr_en && !wr_acc;
        new_err.rd_err = rd_en && !rd_acc;
`ifdef SYNC_FIFO_ERR_STICKY_EN
        err_d          = err_clr ? '0 : (err_q | new_err);
`else
        err_d          = new_err;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q[AW-1:0]] <= data_in;
    end

    // Words in memory plus the FWFT head word must always equal the fill count.
    always_ff @(posedge clk) begin
        if (rst_n) assert (mem_cnt == count_q - PW'(out_valid));
    end

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            sync_fifo_fwft_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
                .clk         (clk),
                .rst_n       (rst_n),
                .pop_i       (rd_acc),
                .mem_empty_i (mem_cnt == '0),
                .mem_data_i  (mem[rd_ptr_q[AW-1:0]]),
                .load_o      (rd_adv),
                .valid_o     (out_valid),
                .data_o      (rd_data)
            );
            assign fifo_empty = !out_valid;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dout_q <= '0;
                else if (rd_acc) dout_q <= mem[rd_ptr_q[AW-1:0]];
            end
            assign rd_adv     = rd_acc;
            assign out_valid  = 1'b0;
            assign fifo_empty = count_q == '0;
            assign rd_data    = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: randomized queue-model bench for sync_fifo_flags, instance 0 standard read, instance 1 FWFT.
module tb_sync_fifo_flags;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en [2];
    logic       rd_en [2];
    logic [7:0] din [2];
    logic [7:0] dout [2];
    logic       full [2], empty [2], af [2], ae [2], werr [2], rerr [2];
    logic [3:0] cnt [2];
`ifdef SYNC_FIFO_ERR_STICKY_EN
    logic       err_clr [2];
`endif

    logic [7:0] q0[$], q1[$];
    logic [7:0] dout_m [2];
    logic       vis;
    logic       werr_m [2], rerr_m [2];
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sync_fifo_flags #(.DATA_WIDTH(8), .DATA_DEPTH(DEPTH), .FWFT(g)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .wr_en        (wr_en[g]),
            .data_in      (din[g]),
            .rd_en        (rd_en[g]),
`ifdef SYNC_FIFO_ERR_STICKY_EN
            .err_clr      (err_clr[g]),
`endif
            .data_out     (dout[g]),
            .full         (full[g]),
            .empty        (empty[g]),
            .almost_full  (af[g]),
            .almost_empty (ae[g]),
            .count        (cnt[g]),
            .wr_err       (werr[g]),
            .rd_err       (rerr[g])
        );
    end

    function automatic logic [9:0] obs(input int m);
        return {full[m], empty[m], af[m], ae[m], werr[m], rerr[m], cnt[m]};
    endfunction

    function automatic logic [9:0] exp_f(input int m);
        int   sz = (m == 0) ? q0.size() : q1.size();
        logic e  = (m == 0) ? (sz == 0) : !vis;
        return {sz == DEPTH, e, sz >= DEPTH - 2, sz <= 2, werr_m[m], rerr_m[m], 4'(sz)};
    endfunction

    function automatic logic dchk(input int m);
        return m == 0 || vis;
    endfunction

    function automatic logic [7:0] exp_d(input int m);
        if (m == 0) return dout_m[0];
        return q1.size() > 0 ? q1[0] : 8'h00;
    endfunction

    // Drive one cycle on instance m and advance the model by the accept rules.
    task automatic step(input int m, input logic w, input logic [7:0] d, input logic r);
        int   sz;
        logic ra, wa, nv;
        wr_en[m] = w; din[m] = d; rd_en[m] = r;
        @(posedge clk);
        sz = (m == 0) ? q0.size() : q1.size();
        ra = r && ((m == 0) ? sz > 0 : vis);
        wa = w && (sz < DEPTH || ra);
`ifdef SYNC_FIFO_ERR_STICKY_EN
        werr_m[m] = !err_clr[m] && (werr_m[m] || (w && !wa));
        rerr_m[m] = !err_clr[m] && (rerr_m[m] || (r && !ra));
`else
        werr_m[m] = w && !wa;
        rerr_m[m] = r && !ra;
`endif
        if (m == 0) begin
            if (ra) dout_m[0] = q0.pop_front();
            if (wa) q0.push_back(d);
        end else begin
            nv = (vis && !ra) || (sz - int'(vis) > 0);
            vis = nv;
            if (ra) void'(q1.pop_front());
            if (wa) q1.push_back(d);
        end
        #1;
        wr_en[m] = 1'b0; rd_en[m] = 1'b0;
    endtask

    task automatic clear_model;
        q0.delete(); q1.delete();
        vis = 1'b0;
        dout_m = '{8'h00, 8'h00};
        werr_m = '{1'b0, 1'b0};
        rerr_m = '{1'b0, 1'b0};
    endtask

    task automatic do_reset;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_model();
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m) !== 10'b0101000000) begin errors++; $display("FAIL reset_flags m=%0d got %b want %b", m, obs(m), 10'b0101000000); end
            checks++;
            if (dout[m] !== 8'h00) begin errors++; $display("FAIL reset_data m=%0d got %h want 00", m, dout[m]); end
        end
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic test_fill_drain;
        for (int i = 1; i <= 2 * DEPTH; i++) begin
            if (i <= DEPTH) step(0, 1'b1, 8'(i), 1'b0);
            else step(0, 1'b0, 8'h00, 1'b1);
            checks++;
            if (obs(0) !== exp_f(0)) begin errors++; $display("FAIL fill_drain_flags i=%0d got %b want %b", i, obs(0), exp_f(0)); end
            checks++;
            if (dout[0] !== exp_d(0)) begin errors++; $display("FAIL fill_drain_data i=%0d got %h want %h", i, dout[0], exp_d(0)); end
        end
    endtask

    task automatic test_full_err;
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(0, 1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 2 * DEPTH + 5; i++) begin
            if (i == 0) step(0, 1'b1, 8'hAA, 1'b0);
            else if (i < 4) step(0, 1'b1, 8'($urandom), 1'b1);
            else if (i == 4) step(0, 1'b0, 8'h00, 1'b0);
            else step(0, 1'b0, 8'h00, 1'b1);
            checks++;
            if (obs(0) !== exp_f(0)) begin errors++; $display("FAIL full_err_flags i=%0d got %b want %b", i, obs(0), exp_f(0)); end
            checks++;
            if (dout[0] !== exp_d(0) || dout[0] === 8'hAA) begin errors++; $display("FAIL full_err_data i=%0d got %h want %h", i, dout[0], exp_d(0)); end
        end
    endtask

    task automatic test_empty_err;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: step(0, 1'b1, 8'h11, 1'b0);
                1: step(0, 1'b0, 8'h00, 1'b1);
                2: step(0, 1'b0, 8'h00, 1'b1);
                3: step(0, 1'b1, 8'h77, 1'b1);
                default: step(0, 1'b0, 8'h00, 1'b1);
            endcase
            checks++;
            if (obs(0) !== exp_f(0)) begin errors++; $display("FAIL empty_err_flags i=%0d got %b want %b", i, obs(0), exp_f(0)); end
            checks++;
            if (dout[0] !== exp_d(0)) begin errors++; $display("FAIL empty_err_data i=%0d got %h want %h", i, dout[0], exp_d(0)); end
        end
    endtask

    task automatic test_fwft_single;
        do_reset();
        step(1, 1'b1, 8'h5C, 1'b0);
        checks++;
        if (empty[1] !== 1'b1 || cnt[1] !== 4'd1) begin errors++; $display("FAIL fwft_edge_n got empty=%b count=%0d want empty=1 count=1", empty[1], cnt[1]); end
        for (int i = 0; i < 3; i++) begin
            step(1, 1'b0, 8'h00, i == 2);
            checks++;
            if (obs(1) !== exp_f(1)) begin errors++; $display("FAIL fwft_single_flags i=%0d got %b want %b", i, obs(1), exp_f(1)); end
            if (i < 2) begin
                checks++;
                if (dout[1] !== 8'h5C || empty[1] !== 1'b0) begin errors++; $display("FAIL fwft_single_data i=%0d got %h empty=%b want 5c empty=0", i, dout[1], empty[1]); end
            end
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int i = 0; i < 4; i++) step(1, i < 3, 8'(8'hE0 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1, 1'b1, 8'($urandom), 1'b1);
            checks++;
            if (obs(1) !== exp_f(1)) begin errors++; $display("FAIL b2b_flags i=%0d got %b want %b", i, obs(1), exp_f(1)); end
            if (dchk(1)) begin
                checks++;
                if (dout[1] !== exp_d(1)) begin errors++; $display("FAIL b2b_data i=%0d got %h want %h", i, dout[1], exp_d(1)); end
            end
        end
    endtask

    task automatic test_random(input int m);
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(m, $urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45);
            checks++;
            if (obs(m) !== exp_f(m)) begin errors++; $display("FAIL random_flags m=%0d i=%0d got %b want %b", m, i, obs(m), exp_f(m)); end
            if (dchk(m)) begin
                checks++;
                if (dout[m] !== exp_d(m)) begin errors++; $display("FAIL random_data m=%0d i=%0d got %h want %h", m, i, dout[m], exp_d(m)); end
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 5; i++) step(m, 1'b1, 8'(8'h90 + i), m == 0 && i == 4);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m) !== exp_f(m)) begin errors++; $display("FAIL pre_reset_flags m=%0d got %b want %b", m, obs(m), exp_f(m)); end
        end
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m) !== 10'b0101000000 || dout[m] !== 8'h00) begin errors++; $display("FAIL async_reset m=%0d got %b data %h want 0101000000 data 00", m, obs(m), dout[m]); end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_model();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 7; i++) begin
                step(m, i < 3, 8'(8'h30 + i), i > 3);
                checks++;
                if (obs(m) !== exp_f(m)) begin errors++; $display("FAIL post_reset_flags m=%0d i=%0d got %b want %b", m, i, obs(m), exp_f(m)); end
                if (dchk(m)) begin
                    checks++;
                    if (dout[m] !== exp_d(m)) begin errors++; $display("FAIL post_reset_data m=%0d i=%0d got %h want %h", m, i, dout[m], exp_d(m)); end
                end
            end
    endtask

`ifdef SYNC_FIFO_ERR_STICKY_EN
    task automatic test_sticky;
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(0, 1'b1, 8'(i), 1'b0);
        step(0, 1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 13; i++) begin
            err_clr[0] = i >= 10;
            if (i == 11) step(0, 1'b1, 8'hBB, 1'b0);
            else if (i == 12) begin err_clr[0] = 1'b0; step(0, 1'b1, 8'hCC, 1'b0); end
            else step(0, 1'b0, 8'h00, 1'b0);
            checks++;
            if (werr[0] !== (i < 10 || i == 12) || obs(0) !== exp_f(0)) begin errors++; $display("FAIL sticky i=%0d got %b want %b", i, obs(0), exp_f(0)); end
        end
        err_clr[0] = 1'b0;
    endtask
`endif

    initial begin
        wr_en = '{1'b0, 1'b0};
        rd_en = '{1'b0, 1'b0};
        din = '{8'h00, 8'h00};
`ifdef SYNC_FIFO_ERR_STICKY_EN
        err_clr = '{1'b0, 1'b0};
`endif
        clear_model();
        test_reset();
        test_fill_drain();
        test_full_err();
        test_empty_err();
        test_fwft_single();
        test_back_to_back();
        test_random(0);
        test_random(1);
        test_async_reset();
`ifdef SYNC_FIFO_ERR_STICKY_EN
        test_sticky();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
